display_scan_mux: RTL
=====================

# display_scan_mux

Time-multiplexed 7-segment display driver sitting directly downstream of `divisor_freq`. It consumes the divider's free-running 18-bit count (50 MHz, wraps at 18'h3FFFE → 0, ≈190 Hz), and turns each wrap into a scan tick. It cycles a one-hot digit select across the board's common-anode digits and drives decoded segment patterns from a frame-coherent snapshot of the BCD/hex input.

## Interface
- `DIGITS`, 4, number of multiplexed digits (2..8)
- `SEG_ACTIVE_LOW`, 1, 1 = segments/dp active-low; 0 = outputs inverted to active-high (digit select is always active-low)
- `clock_in`  input  1  system clock, 50 MHz; one clock domain
- `reset_n`  input  1  synchronous, active-low reset
- `div_count`  input  18  count from `divisor_freq.clock_out`
- `enable`  input  1  1 = scan; 0 = display blanked
- `digits_bcd`  input  4*DIGITS  nibble i = value of digit i; digit 0 is least significant (rightmost)
- `dp_in`  input  DIGITS  decimal point per digit, 1 = lit
- `digit_sel`  output  DIGITS  one-hot active-low digit enable
- `segments`  output  7  {g,f,e,d,c,b,a}
- `dp_out`  output  1  decimal point of the selected digit
- `frame_start`  output  1  one-cycle pulse when digit 0 is selected with a new snapshot

## Operation
- Tick detect: `prev_count` register holds last `div_count`; `tick` = (`div_count` == 0) && (`prev_count` != 0). `div_count` held at 0 gives one tick only.
- States: BLANK, SCAN.
  - BLANK: all outputs off. On `tick` && `enable`: snapshot `digits_bcd`/`dp_in` into shadow, idx = 0, pulse `frame_start`, → SCAN.
  - SCAN: on `tick`: if idx == DIGITS-1 → idx = 0, take new snapshot, pulse `frame_start`; else idx = idx+1, shadow unchanged.
  - `enable` = 0 in any state → BLANK on the next edge (wins over a simultaneous `tick`).
- Decode of shadow[idx] (active-low codes): 0 40, 1 79, 2 24, 3 30, 4 19, 5 12, 6 02, 7 78, 8 00, 9 10, A 08, b 03, C 46, d 21, E 06, F 0E. Off = 7F.
- `SEG_ACTIVE_LOW` = 0: `segments` and `dp_out` bitwise inverted (off = 00, dp off = 0).
- `digit_sel` = ~(1 << idx) in SCAN; all ones in BLANK.
- Input changes between frames never appear mid-frame; all digits of one frame come from the same snapshot.

## Timing
- Reset values: state BLANK, idx 0, shadow 0, `prev_count` 0, `digit_sel` all ones, `segments` 7F, `dp_out` 1 (active-low polarity; 00/0 otherwise), `frame_start` 0.
- Reset applied mid-scan returns to these values on the next edge; scan restarts at digit 0 on the first tick after release with `enable` = 1.
- Latency: edge k samples first `div_count` == 0; `digit_sel`/`segments`/`dp_out`/`frame_start` update at edge k+1 (all outputs registered, no combinational path from inputs to outputs).
- `frame_start` high exactly one cycle; digit dwell = one divider period (262143 cycles).
- `enable` falling: outputs blank at next edge. `enable` rising: stays blank until next tick.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: at snapshot, compute blank mask; digits DIGITS-1 downward that are 0 are blanked (segments off) until the first nonzero digit; digit 0 is never blanked. Decimal point of a blanked digit is still driven from `dp_in`.
- Not defined: every digit displayed, including leading zeros; no mask logic.

## Structure
- Shared package `display_pkg`: `DIV_WIDTH` = 18, segment code constants (0–F, `SEG_OFF`), state enum {BLANK, SCAN}.
- Sub-module `hex_to_7seg`: combinational 4-bit → 7-bit active-low decoder, instanced once on the selected shadow nibble.

## Test plan
- Reset: `reset_n` = 0 for 3 cycles → `digit_sel` 1111, `segments` 7F, `dp_out` 1, `frame_start` 0.
- Scan: `digits_bcd` = 16'h1234, `enable` = 1, four 18'h3FFFE→0 wraps → `digit_sel` 1110/1101/1011/0111 with `segments` 19/30/24/79; `frame_start` only with digit 0, one cycle after the wrap.
- Snapshot: change `digits_bcd` to 16'h5678 while digit 1 is selected → digits 2,3 still show 2,1; next frame shows 8,7,6,5.
- Enable/tick race: `enable` = 0 in the same cycle as a tick → next edge `digit_sel` 1111; re-enable → blank until next tick, then digit 0 with `frame_start`.
- Held zero: `div_count` = 0 for 5 cycles → exactly one idx advance.
- `LEADING_ZERO_BLANK_EN`: 16'h0050 → digits 3,2 = 7F, digit 1 = 12, digit 0 = 40; 16'h0000 → only digit 0 shows 40; macro undefined → 16'h0050 shows 40,40,12,40.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver.
package display_pkg;

  localparam int unsigned DIV_WIDTH = 18;
  localparam int unsigned SEG_WIDTH = 7;
  localparam int unsigned NIB_WIDTH = 4;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_WIDTH-1:0] SEG_0   = 7'h40;
  localparam logic [SEG_WIDTH-1:0] SEG_1   = 7'h79;
  localparam logic [SEG_WIDTH-1:0] SEG_2   = 7'h24;
  localparam logic [SEG_WIDTH-1:0] SEG_3   = 7'h30;
  localparam logic [SEG_WIDTH-1:0] SEG_4   = 7'h19;
  localparam logic [SEG_WIDTH-1:0] SEG_5   = 7'h12;
  localparam logic [SEG_WIDTH-1:0] SEG_6   = 7'h02;
  localparam logic [SEG_WIDTH-1:0] SEG_7   = 7'h78;
  localparam logic [SEG_WIDTH-1:0] SEG_8   = 7'h00;
  localparam logic [SEG_WIDTH-1:0] SEG_9   = 7'h10;
  localparam logic [SEG_WIDTH-1:0] SEG_A   = 7'h08;
  localparam logic [SEG_WIDTH-1:0] SEG_B   = 7'h03;
  localparam logic [SEG_WIDTH-1:0] SEG_C   = 7'h46;
  localparam logic [SEG_WIDTH-1:0] SEG_D   = 7'h21;
  localparam logic [SEG_WIDTH-1:0] SEG_E   = 7'h06;
  localparam logic [SEG_WIDTH-1:0] SEG_F   = 7'h0E;
  localparam logic [SEG_WIDTH-1:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    BLANK = 1'b0,
    SCAN  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/display_scan_mux_hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [NIB_WIDTH-1:0] i_nibble,
  output logic [SEG_WIDTH-1:0] o_seg_c
);

  // Nibble lookup into the shared segment code table
  always_comb begin
    o_seg_c = SEG_OFF;
    case (i_nibble)
      4'h0: o_seg_c = SEG_0;
      4'h1: o_seg_c = SEG_1;
      4'h2: o_seg_c = SEG_2;
      4'h3: o_seg_c = SEG_3;
      4'h4: o_seg_c = SEG_4;
      4'h5: o_seg_c = SEG_5;
      4'h6: o_seg_c = SEG_6;
      4'h7: o_seg_c = SEG_7;
      4'h8: o_seg_c = SEG_8;
      4'h9: o_seg_c = SEG_9;
      4'hA: o_seg_c = SEG_A;
      4'hB: o_seg_c = SEG_B;
      4'hC: o_seg_c = SEG_C;
      4'hD: o_seg_c = SEG_D;
      4'hE: o_seg_c = SEG_E;
      4'hF: o_seg_c = SEG_F;
    endcase
  end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed 7-segment scan driver fed by the divisor_freq count.
// Each divider wrap advances the selected digit; a full frame is drawn
// from one snapshot of the inputs. Optional leading-zero blanking is
// enabled by defining LEADING_ZERO_BLANK_EN.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                        clock_in,
  input  logic                        reset_n,
  input  logic [DIV_WIDTH-1:0]        div_count,
  input  logic                        enable,
  input  logic [NIB_WIDTH*DIGITS-1:0] digits_bcd,
  input  logic [DIGITS-1:0]           dp_in,
  output logic [DIGITS-1:0]           digit_sel,
  output logic [SEG_WIDTH-1:0]        segments,
  output logic                        dp_out,
  output logic                        frame_start
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BCD_W = NIB_WIDTH * DIGITS;
  localparam logic [SEG_WIDTH-1:0] SEG_IDLE = SEG_ACTIVE_LOW ? SEG_OFF : SEG_WIDTH'(~SEG_OFF);
  localparam logic                 DP_IDLE  = SEG_ACTIVE_LOW;

  // Scan-side state
  scan_state_e         r_state;
  scan_state_e         w_state_next;
  logic [DIV_WIDTH-1:0] r_prev_count;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_next;
  logic [BCD_W-1:0]    r_shadow;
  logic [BCD_W-1:0]    w_shadow_next;
  logic [DIGITS-1:0]   r_dp_shadow;
  logic [DIGITS-1:0]   w_dp_shadow_next;
  logic                r_new_frame;
  logic                w_new_frame_next;
  logic                w_take_snapshot;
  logic                w_tick;

  // Output stage
  logic [DIGITS-1:0]    w_digit_sel_next;
  logic [SEG_WIDTH-1:0] w_seg_n;
  logic                 w_dp_n;
  logic [SEG_WIDTH-1:0] w_segments_next;
  logic                 w_dp_out_next;
  logic                 w_frame_start_next;
  logic [NIB_WIDTH-1:0] w_sel_nibble;
  logic [SEG_WIDTH-1:0] w_seg_code;
  logic                 w_sel_blank;

  // One tick per transition into zero; a held zero does not retrigger
  assign w_tick = (div_count == '0) && (r_prev_count != '0);

  // Wrap detector history
  always_ff @(posedge clock_in) begin
    if (!reset_n) r_prev_count <= '0;
    else          r_prev_count <= div_count;
  end

  // Next scan state, digit index and snapshot capture
  always_comb begin
    w_state_next     = r_state;
    w_idx_next       = r_idx;
    w_shadow_next    = r_shadow;
    w_dp_shadow_next = r_dp_shadow;
    w_new_frame_next = 1'b0;
    w_take_snapshot  = 1'b0;
    if (!enable) begin
      w_state_next = BLANK;
    end else begin
      case (r_state)
        BLANK: begin
          if (w_tick) begin
            w_state_next    = SCAN;
            w_take_snapshot = 1'b1;
          end
        end
        SCAN: begin
          if (w_tick) begin
            if (r_idx == IDX_W'(DIGITS - 1)) w_take_snapshot = 1'b1;
            else                             w_idx_next      = r_idx + IDX_W'(1);
          end
        end
      endcase
    end
    if (w_take_snapshot) begin
      w_idx_next       = '0;
      w_shadow_next    = digits_bcd;
      w_dp_shadow_next = dp_in;
      w_new_frame_next = 1'b1;
    end
  end

  // Scan state register
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_state     <= BLANK;
      r_idx       <= '0;
      r_shadow    <= '0;
      r_dp_shadow <= '0;
      r_new_frame <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_shadow    <= w_shadow_next;
      r_dp_shadow <= w_dp_shadow_next;
      r_new_frame <= w_new_frame_next;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] r_blank_mask;
  logic [DIGITS-1:0] w_lz_mask;
  logic              w_seen_nz;

  // Blank zeros from the top digit down until the first nonzero; digit 0 always shown
  always_comb begin
    w_lz_mask = '0;
    w_seen_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (digits_bcd[NIB_WIDTH*i +: NIB_WIDTH] != 4'h0) w_seen_nz = 1'b1;
      w_lz_mask[i] = !w_seen_nz;
    end
  end

  // Mask follows the shadow so it stays frame-coherent
  always_ff @(posedge clock_in) begin
    if (!reset_n)             r_blank_mask <= '0;
    else if (w_take_snapshot) r_blank_mask <= w_lz_mask;
  end

  assign w_sel_blank = r_blank_mask[r_idx];
`else
  assign w_sel_blank = 1'b0;
`endif

  assign w_sel_nibble = r_shadow[{r_idx, 2'b00} +: NIB_WIDTH];

  hex_to_7seg u_hex_to_7seg (
    .i_nibble (w_sel_nibble),
    .o_seg_c  (w_seg_code)
  );

  // Output decode; enable low blanks immediately on the same edge as the state change
  always_comb begin
    w_digit_sel_next   = '1;
    w_seg_n            = SEG_OFF;
    w_dp_n             = 1'b1;
    w_frame_start_next = 1'b0;
    if (enable && (r_state == SCAN)) begin
      w_digit_sel_next   = ~(DIGITS'(1) << r_idx);
      w_seg_n            = w_sel_blank ? SEG_OFF : w_seg_code;
      w_dp_n             = ~r_dp_shadow[r_idx];
      w_frame_start_next = r_new_frame;
    end
    w_segments_next = SEG_ACTIVE_LOW ? w_seg_n : ~w_seg_n;
    w_dp_out_next   = SEG_ACTIVE_LOW ? w_dp_n : ~w_dp_n;
  end

  // Registered display outputs
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      digit_sel   <= '1;
      segments    <= SEG_IDLE;
      dp_out      <= DP_IDLE;
      frame_start <= 1'b0;
    end else begin
      digit_sel   <= w_digit_sel_next;
      segments    <= w_segments_next;
      dp_out      <= w_dp_out_next;
      frame_start <= w_frame_start_next;
    end
  end

endmodule
